tile_line_renderer: RTL

TILE_LINE_RENDERER -- requirements
Module: tile_line_renderer

---
 rtl/tile_line_renderer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/tile_line_renderer.sv
// Renders one scanline of a tile map: fetches each tile byte, then its graphics row,
// and emits 16 two-bit pixels per tile into the line buffer, one per cycle.
module tile_line_renderer #(
  parameter int TILE_COLS     = 40,
  parameter int VISIBLE_LINES = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [9:0]  line_y,
  output logic [8:0]  tb_addr,
  input  logic [31:0] tb_rdata,
  output logic [10:0] tg_addr,
  input  logic [31:0] tg_rdata,
  output logic        lb_we,
  output logic [9:0]  lb_addr,
  output logic [2:0]  lb_wdata,
  output logic        busy,
  output logic        done
);

  localparam int CW  = $clog2(TILE_COLS);
  localparam int WPL = TILE_COLS / 4;

  // line_start is a single-cycle request with no ready: it is taken only in IDLE
  // and silently dropped at any other time (busy=1 tells the requester why).
  typedef enum logic [2:0] {
    IDLE, TB_REQ, TB_CAP, TG_REQ, TG_CAP, EMIT, DONE
  } state_t;

  state_t         state, state_nxt;
  logic [9:0]     line_q;
  logic [CW-1:0]  col;
  logic [3:0]     px;
  logic [7:0]     tile_q;
  logic [31:0]    gfx_q;
  logic [7:0]     lane_byte;
  logic [31:0]    gfx_sh;
  logic           last_px, last_col, line_ok;

  function automatic logic [8:0] tb_word(input logic [5:0] row, input logic [CW-1:0] c);
    return 9'(row) * 9'(WPL) + 9'(c >> 2);
  endfunction

  assign last_px  = (px == 4'd15);
  assign last_col = (col == CW'(TILE_COLS - 1));
  assign line_ok  = (32'(line_y) < VISIBLE_LINES);

  always_comb begin
    lane_byte = 8'd0;
    case (col[1:0])
      2'd0: lane_byte = tb_rdata[7:0];
      2'd1: lane_byte = tb_rdata[15:8];
      2'd2: lane_byte = tb_rdata[23:16];
      2'd3: lane_byte = tb_rdata[31:24];
      default: lane_byte = 8'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (line_start) state_nxt = line_ok ? TB_REQ : DONE;
      TB_REQ:  state_nxt = TB_CAP;
      TB_CAP:  state_nxt = TG_REQ;
      TG_REQ:  state_nxt = TG_CAP;
      TG_CAP:  state_nxt = EMIT;
      EMIT:    if (last_px) state_nxt = last_col ? DONE : TB_REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Addresses are registered on the way into the REQ states so they hold afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q  <= 10'd0;
      col     <= '0;
      px      <= 4'd0;
      tile_q  <= 8'd0;
      gfx_q   <= 32'd0;
      tb_addr <= 9'd0;
      tg_addr <= 11'd0;
    end else begin
      case (state)
        IDLE: begin
          if (line_start && line_ok) begin
            line_q  <= line_y;
            col     <= '0;
            tb_addr <= tb_word(line_y[9:4], '0);
          end
        end
        TB_CAP: begin
          tile_q  <= lane_byte;
          tg_addr <= {lane_byte[6:0], line_q[3:0]};
        end
        TG_CAP: begin
          gfx_q <= tg_rdata;
          px    <= 4'd0;
        end
        EMIT: begin
          px <= px + 4'd1;
          if (last_px && !last_col) begin
            col     <= col + CW'(1);
            tb_addr <= tb_word(line_q[9:4], col + CW'(1));
          end
        end
        default: ;
      endcase
    end
  end

  assign gfx_sh   = gfx_q >> {px, 1'b0};
  assign lb_we    = (state == EMIT);
  assign lb_addr  = 10'({col, px});
  assign lb_wdata = {tile_q[7], gfx_sh[1:0]};
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule
